iic_config_sequencer: RTL and testbench
=======================================

# iic_config_sequencer

Upstream driver for the I2C byte-write transmitter. Walks a table of N_REGS (word address, data) pairs and presents each pair with a fixed 7-bit device address. Holds the transmitter's level-sensitive send enable for each write, waits for its done pulse, inserts an idle gap, then advances. Retries a write that times out (NACK restarts the transmitter silently), and reports completion or failure to the system controller.

## Interface
- N_REGS, 16: table entries, 1..256
- DEV_ADDR, 7'h21: 7-bit device address driven on o_dev_addr
- GAP_CYCLES, 8: idle cycles with send enable low between writes, ≥2
- TIMEOUT, 4096: cycles to wait for done before a retry, ≥16
- MAX_RETRY, 3: retries per entry before error, 0..15
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  pulse; begins a sequence from entry 0; ignored while o_busy
- i_done_flag  in  1  one-cycle done pulse from the transmitter
- o_iic_send_en  out  1  level enable to the transmitter
- o_dev_addr  out  7  constant DEV_ADDR
- o_word_addr  out  8  word address of the current entry
- o_write_data  out  8  data byte of the current entry
- o_busy  out  1  high from the cycle after accepted i_start until DONE/ERR is entered
- o_cfg_done  out  1  sticky; all entries written
- o_cfg_err  out  1  sticky; an entry exhausted its retries
- o_err_index  out  8  entry index that failed; valid while o_cfg_err

## Operation
- States: IDLE, LOAD, SEND, GAP, DONE, ERR.
- IDLE: send_en=0. i_start → LOAD, idx=0, retry=0, clear o_cfg_done/o_cfg_err.
- LOAD: register the table entry at idx into o_word_addr/o_write_data; timer=0 → SEND.
- SEND: send_en=1, timer increments.
  - i_done_flag → GAP.
  - timer==TIMEOUT-1 without done → GAP with retry flag set.
- GAP: send_en=0 for GAP_CYCLES cycles. This returns the transmitter to its idle state and blocks back-to-back restarts. On exit:
  - Retry flag set and retry<MAX_RETRY → retry+1 → LOAD, same idx.
  - Retry flag set and retry==MAX_RETRY → ERR, o_err_index=idx.
  - Otherwise idx==N_REGS-1 → DONE; else idx+1, retry=0 → LOAD.
- DONE/ERR: set the sticky flag, send_en=0 → IDLE the next cycle. Flags hold until the next accepted i_start or reset.
- i_done_flag outside SEND is ignored.
- i_done_flag on the same cycle the timer expires counts as success; done has priority.
- i_start during a sequence is ignored. i_start on the cycle DONE/ERR returns to IDLE is ignored; the one after is accepted.
- Index and retry counters use saturating compare, never wrap. idx is 8 bits, retry is 4 bits, timer is clog2(TIMEOUT) bits.

## Timing
- Reset values: o_iic_send_en=0, o_word_addr=0, o_write_data=0, o_busy=0, o_cfg_done=0, o_cfg_err=0, o_err_index=0; state IDLE.
- Reset mid-sequence drops send_en on the next edge. The transmitter aborts because it only runs while enabled.
- i_start at edge k → LOAD at k+1 → send_en=1 from edge k+2.
- Address and data are stable for the entire SEND state and change only in LOAD, while send_en=0.
- Successful entry: done seen at edge d → send_en=0 from d+1. Next send_en rises at d+GAP_CYCLES+2, one LOAD cycle after the gap.
- o_cfg_done rises one cycle after the final GAP completes. o_busy falls on the same edge.

## Structure
- Package iic_cfg_pkg holds the state enum, the default DEV_ADDR, and the table entry type {word_addr[7:0], data[7:0]}.
- Sub-module iic_config_rom: combinational lookup, idx → 16-bit entry, case-based, default entry 16'h0000. The sequencer registers its output in LOAD.

## Test plan
- N_REGS=4, transmitter model pulses done 200 cycles after send_en rises → four writes in table order; o_word_addr/o_write_data match ROM entries 0..3; each send_en low gap equals GAP_CYCLES; o_cfg_done=1, o_cfg_err=0.
- Model never pulses done on entry 2, MAX_RETRY=3, TIMEOUT=64 → four SEND windows of 64 cycles for entry 2; then o_cfg_err=1, o_err_index=2, o_cfg_done=0, send_en=0.
- Entry 1 times out once, then done arrives 30 cycles into the retry → single retry, sequence completes, o_cfg_err=0.
- Done pulse on the same cycle as timer expiry → treated as success; idx advances with no retry.
- i_rst asserted 50 cycles into entry 3 → next cycle send_en=0, all outputs at reset values; a fresh i_start restarts at entry 0.
- i_start pulses during busy and a stray i_done_flag during GAP → no effect on idx, retry, or outputs.

Source files
------------

// File: rtl/iic_cfg_pkg.sv
// Shared types for the I2C configuration sequencer.
//   cfg_state_e      : sequencer state encoding
//   DEFAULT_DEV_ADDR : default 7-bit device address
//   cfg_entry_t      : one table entry {word_addr, data}
package iic_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h21;

  typedef struct packed {
    logic [7:0] word_addr;
    logic [7:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/iic_config_rom.sv
// Register table for the configuration sequencer. Purely combinational.
//   idx_i   : table index
//   entry_o : {word_addr, data} for idx_i; zero for unused indices
module iic_config_rom
  import iic_cfg_pkg::*;
(
  input  logic [7:0] idx_i,
  output cfg_entry_t entry_o
);

  always_comb begin
    entry_o = '0;
    unique case (idx_i)
      8'd0:    entry_o = '{word_addr: 8'h00, data: 8'h80};
      8'd1:    entry_o = '{word_addr: 8'h01, data: 8'h3C};
      8'd2:    entry_o = '{word_addr: 8'h02, data: 8'hA5};
      8'd3:    entry_o = '{word_addr: 8'h03, data: 8'h0F};
      8'd4:    entry_o = '{word_addr: 8'h10, data: 8'h44};
      8'd5:    entry_o = '{word_addr: 8'h11, data: 8'h12};
      8'd6:    entry_o = '{word_addr: 8'h12, data: 8'hFE};
      8'd7:    entry_o = '{word_addr: 8'h20, data: 8'h01};
      8'd8:    entry_o = '{word_addr: 8'h21, data: 8'h77};
      8'd9:    entry_o = '{word_addr: 8'h22, data: 8'h9B};
      8'd10:   entry_o = '{word_addr: 8'h30, data: 8'h5A};
      8'd11:   entry_o = '{word_addr: 8'h31, data: 8'hC3};
      8'd12:   entry_o = '{word_addr: 8'h40, data: 8'h08};
      8'd13:   entry_o = '{word_addr: 8'h41, data: 8'h60};
      8'd14:   entry_o = '{word_addr: 8'h50, data: 8'hE1};
      8'd15:   entry_o = '{word_addr: 8'h51, data: 8'h2D};
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/iic_config_sequencer.sv
// Drives the I2C byte-write transmitter through the register table.
// Each entry is presented with a level send enable until the transmitter's
// done pulse, followed by an enforced idle gap. A write that times out is
// retried up to MAX_RETRY times before the sequence stops with an error.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_start            : start pulse (ignored while busy)
//   i_done_flag        : one-cycle done pulse from the transmitter
//   o_iic_send_en      : level enable to the transmitter
//   o_dev_addr         : constant device address
//   o_word_addr        : word address of current entry
//   o_write_data       : data byte of current entry
//   o_busy             : sequence in progress
//   o_cfg_done         : sticky, all entries written
//   o_cfg_err          : sticky, an entry exhausted its retries
//   o_err_index        : failing entry index, valid with o_cfg_err
module iic_config_sequencer
  import iic_cfg_pkg::*;
#(
  parameter int unsigned N_REGS     = 16,
  parameter logic [6:0]  DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_done_flag,
  output logic       o_iic_send_en,
  output logic [6:0] o_dev_addr,
  output logic [7:0] o_word_addr,
  output logic [7:0] o_write_data,
  output logic       o_busy,
  output logic       o_cfg_done,
  output logic       o_cfg_err,
  output logic [7:0] o_err_index
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = $clog2(GAP_CYCLES);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(N_REGS - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  cfg_state_e    state_q;
  logic [7:0]    idx_q;
  logic [3:0]    retry_q;
  logic          retry_flag_q;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_q;
  logic          send_en_q;
  logic [7:0]    word_q;
  logic [7:0]    data_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    err_idx_q;
  cfg_entry_t    rom_entry;

  iic_config_rom u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  // Registered outputs change on the edge that enters the new state, so
  // send_en is high exactly while in SEND and busy/flags update on entry to
  // DONE/ERR.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      retry_q      <= '0;
      retry_flag_q <= 1'b0;
      timer_q      <= '0;
      gap_q        <= '0;
      send_en_q    <= 1'b0;
      word_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_idx_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            retry_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_LOAD: begin
          word_q       <= rom_entry.word_addr;
          data_q       <= rom_entry.data;
          timer_q      <= '0;
          retry_flag_q <= 1'b0;
          send_en_q    <= 1'b1;
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          timer_q <= timer_q + 1'b1;
          // Done wins over a simultaneous timeout.
          if (i_done_flag) begin
            send_en_q <= 1'b0;
            gap_q     <= '0;
            state_q   <= ST_GAP;
          end else if (timer_q >= TMR_LAST) begin
            send_en_q    <= 1'b0;
            gap_q        <= '0;
            retry_flag_q <= 1'b1;
            state_q      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q >= GAP_LAST) begin
            if (retry_flag_q) begin
              if (retry_q < RETRY_MAX) begin
                retry_q <= retry_q + 4'd1;
                state_q <= ST_LOAD;
              end else begin
                err_idx_q <= idx_q;
                err_q     <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= ST_ERR;
              end
            end else if (idx_q >= IDX_LAST) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 8'd1;
              retry_q <= '0;
              state_q <= ST_LOAD;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_DONE, ST_ERR: state_q <= ST_IDLE;
        default:         state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_iic_send_en = send_en_q;
  assign o_dev_addr    = DEV_ADDR;
  assign o_word_addr   = word_q;
  assign o_write_data  = data_q;
  assign o_busy        = busy_q;
  assign o_cfg_done    = done_q;
  assign o_cfg_err     = err_q;
  assign o_err_index   = err_idx_q;

endmodule

// File: tb/tb_iic_config_sequencer.sv
// Self-checking bench for iic_config_sequencer. A transmitter model answers
// each send window after a planned delay; a reference model derives the
// expected windows and final flags from the same plan.
module tb_iic_config_sequencer;

  localparam int unsigned NR  = 4;
  localparam int unsigned GAP = 8;
  localparam int unsigned TO  = 64;
  localparam int unsigned MR  = 3;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       done_flag = 1'b0;
  logic       send_en;
  logic [6:0] dev_addr;
  logic [7:0] word_addr;
  logic [7:0] write_data;
  logic       busy;
  logic       cfg_done;
  logic       cfg_err;
  logic [7:0] err_index;

  always #5 clk = ~clk;

  iic_config_sequencer #(
    .N_REGS     (NR),
    .DEV_ADDR   (7'h21),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TO),
    .MAX_RETRY  (MR)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_done_flag   (done_flag),
    .o_iic_send_en (send_en),
    .o_dev_addr    (dev_addr),
    .o_word_addr   (word_addr),
    .o_write_data  (write_data),
    .o_busy        (busy),
    .o_cfg_done    (cfg_done),
    .o_cfg_err     (cfg_err),
    .o_err_index   (err_index)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [15:0] rom_ref [0:15];

  // Transmitter model: each send window consumes one planned delay n; done
  // is presented so the sequencer samples it on the n-th edge of the window.
  int tx_plan[$];
  int tx_n = NEVER;
  int tx_cnt = 0;
  logic tx_prev = 1'b0;
  bit stray_en = 1'b0;

  always @(negedge clk) begin
    if (send_en && !tx_prev) begin
      tx_cnt = 1;
      tx_n = (tx_plan.size() > 0) ? tx_plan.pop_front() : NEVER;
    end else if (send_en) begin
      tx_cnt = tx_cnt + 1;
    end
    tx_prev = send_en;
    if (send_en) done_flag = (tx_cnt == tx_n);
    else         done_flag = stray_en && busy && ($urandom_range(0, 7) == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  int plan[$];
  int exp_idx[$];
  int exp_len[$];
  logic se_t[$];
  logic [7:0] wa_t[$];
  logic [7:0] wd_t[$];

  task automatic run_seq(input bit poke);
    bit exp_err;
    int exp_eidx;
    int k;
    int cyc;
    bit ended;
    int rises[$];
    int falls[$];
    int nw;
    logic prev;
    logic [15:0] rv;

    // Reference: attempts per entry until success or retries exhausted.
    exp_idx.delete();
    exp_len.delete();
    exp_err = 0;
    exp_eidx = 0;
    k = 0;
    for (int e = 0; e < int'(NR) && !exp_err; e++) begin
      for (int r = 0; r <= int'(MR); r++) begin
        int n;
        n = (k < plan.size()) ? plan[k] : NEVER;
        k++;
        exp_idx.push_back(e);
        exp_len.push_back((n <= int'(TO)) ? n : int'(TO));
        if (n <= int'(TO)) break;
        if (r == int'(MR)) begin
          exp_err = 1;
          exp_eidx = e;
        end
      end
    end

    tx_plan = plan;
    se_t.delete();
    wa_t.delete();
    wd_t.delete();

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);

    cyc = 0;
    ended = 0;
    while (cyc < 5000) begin
      se_t.push_back(send_en);
      wa_t.push_back(word_addr);
      wd_t.push_back(write_data);
      if (!busy) begin
        ended = 1;
        break;
      end
      start = poke && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("seq_ends", {31'd0, ended}, 32'd1);

    for (int m = 0; m < se_t.size(); m++) begin
      prev = (m == 0) ? 1'b0 : se_t[m-1];
      if (se_t[m] && !prev) rises.push_back(m);
      if (!se_t[m] && prev) falls.push_back(m);
    end
    check("window_count", rises.size(), exp_idx.size());

    nw = rises.size();
    if (falls.size() < nw) nw = falls.size();
    if (exp_idx.size() < nw) nw = exp_idx.size();
    for (int w = 0; w < nw; w++) begin
      rv = rom_ref[exp_idx[w]];
      check("word_addr", {24'd0, wa_t[rises[w]]}, {24'd0, rv[15:8]});
      check("write_data", {24'd0, wd_t[rises[w]]}, {24'd0, rv[7:0]});
      check("entry_stable", {16'd0, wa_t[falls[w]-1], wd_t[falls[w]-1]}, {16'd0, rv});
      check("window_len", falls[w] - rises[w], exp_len[w]);
      if (w == 0) check("start_latency", rises[0], 1);
      else        check("gap_len", rises[w] - falls[w-1], GAP + 1);
    end
    if (falls.size() > 0)
      check("busy_fall", se_t.size() - 1 - falls[falls.size()-1], GAP);

    check("cfg_done", {31'd0, cfg_done}, {31'd0, !exp_err});
    check("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
    if (exp_err) check("err_index", {24'd0, err_index}, exp_eidx);
    check("send_en_end", {31'd0, send_en}, 32'd0);

    // Start on the DONE/ERR -> IDLE cycle must be ignored; flags hold.
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_at_end_ignored", {31'd0, busy}, 32'd0);
    check("flags_hold", {30'd0, cfg_err, cfg_done}, {30'd0, exp_err, !exp_err});
  endtask

  initial begin
    int cnt;
    logic p;
    rom_ref[0]  = 16'h0080; rom_ref[1]  = 16'h013C; rom_ref[2]  = 16'h02A5; rom_ref[3]  = 16'h030F;
    rom_ref[4]  = 16'h1044; rom_ref[5]  = 16'h1112; rom_ref[6]  = 16'h12FE; rom_ref[7]  = 16'h2001;
    rom_ref[8]  = 16'h2177; rom_ref[9]  = 16'h229B; rom_ref[10] = 16'h305A; rom_ref[11] = 16'h31C3;
    rom_ref[12] = 16'h4008; rom_ref[13] = 16'h4160; rom_ref[14] = 16'h50E1; rom_ref[15] = 16'h512D;

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send_en", {31'd0, send_en}, 32'd0);
    check("rst_word", {24'd0, word_addr}, 32'd0);
    check("rst_data", {24'd0, write_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, cfg_done}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    check("rst_err_index", {24'd0, err_index}, 32'd0);
    check("dev_addr", {25'd0, dev_addr}, 32'h21);
    rst = 1'b0;
    stray_en = 1'b1;

    // All entries succeed, random latency, busy-time start pulses and stray done.
    plan.delete();
    for (int i = 0; i < int'(NR); i++) plan.push_back($urandom_range(1, TO - 1));
    run_seq(1);

    // Entry 2 never answers: retries exhausted.
    plan.delete();
    plan.push_back($urandom_range(1, TO - 1));
    plan.push_back($urandom_range(1, TO - 1));
    for (int i = 0; i <= int'(MR); i++) plan.push_back(NEVER);
    run_seq(1);

    // Entry 1 times out once, then answers 30 cycles into the retry.
    plan.delete();
    plan.push_back($urandom_range(1, TO - 1));
    plan.push_back(NEVER);
    plan.push_back(30);
    plan.push_back($urandom_range(1, TO - 1));
    plan.push_back($urandom_range(1, TO - 1));
    run_seq(0);

    // Done coincident with timer expiry counts as success; minimum latency too.
    plan.delete();
    plan.push_back(TO);
    plan.push_back(1);
    plan.push_back(TO);
    plan.push_back(TO - 1);
    run_seq(1);

    // Random mixes of timeouts and successes.
    for (int s = 0; s < 3; s++) begin
      plan.delete();
      for (int i = 0; i < int'(NR * (MR + 1)); i++)
        plan.push_back(($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, TO)));
      run_seq(1);
    end

    // Reset 50 cycles into entry 3, then a clean restart from entry 0.
    stray_en = 1'b0;
    plan.delete();
    for (int i = 0; i < 3; i++) plan.push_back($urandom_range(1, TO - 1));
    plan.push_back(60);
    tx_plan = plan;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    p = 1'b0;
    for (int c = 0; c < 2000 && cnt < 4; c++) begin
      if (send_en && !p) cnt++;
      p = send_en;
      if (cnt < 4) @(negedge clk);
    end
    check("reached_entry3", cnt, 4);
    repeat (50) @(negedge clk);
    check("entry3_sending", {31'd0, send_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_send_en", {31'd0, send_en}, 32'd0);
    check("mid_rst_word", {24'd0, word_addr}, 32'd0);
    check("mid_rst_data", {24'd0, write_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_flags", {30'd0, cfg_err, cfg_done}, 32'd0);
    check("mid_rst_err_index", {24'd0, err_index}, 32'd0);
    rst = 1'b0;
    tx_plan.delete();
    plan.delete();
    for (int i = 0; i < int'(NR); i++) plan.push_back($urandom_range(1, TO));
    run_seq(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
